// File: rtl/jtkcpu_brunit_pkg.sv
// Shared JTKCPU branch definitions: opcode values, CC bit positions,
// branch-form classes and the opcode-to-form decoder.
package jtkcpu_brunit_pkg;

  localparam logic [7:0] OP_BRA      = 8'h20;
  localparam logic [7:0] OP_BRN      = 8'h21;
  localparam logic [7:0] OP_BHI      = 8'h22;
  localparam logic [7:0] OP_BLS      = 8'h23;
  localparam logic [7:0] OP_BCC      = 8'h24;
  localparam logic [7:0] OP_BCS      = 8'h25;
  localparam logic [7:0] OP_BNE      = 8'h26;
  localparam logic [7:0] OP_BEQ      = 8'h27;
  localparam logic [7:0] OP_BVC      = 8'h28;
  localparam logic [7:0] OP_BVS      = 8'h29;
  localparam logic [7:0] OP_BPL      = 8'h2A;
  localparam logic [7:0] OP_BMI      = 8'h2B;
  localparam logic [7:0] OP_BGE      = 8'h2C;
  localparam logic [7:0] OP_BLT      = 8'h2D;
  localparam logic [7:0] OP_BGT      = 8'h2E;
  localparam logic [7:0] OP_BLE      = 8'h2F;
  localparam logic [7:0] OP_LBRA     = 8'h30;  // long forms: 0x30..0x3F mirror 0x20..0x2F
  localparam logic [7:0] OP_LBGT     = 8'h3E;
  localparam logic [7:0] OP_LBSR     = 8'h17;
  localparam logic [7:0] OP_BSR      = 8'h8D;
  localparam logic [7:0] OP_DECB_JNZ = 8'h8A;
  localparam logic [7:0] OP_DECX_JNZ = 8'h8B;

  localparam int CC_C = 0;
  localparam int CC_V = 1;
  localparam int CC_Z = 2;
  localparam int CC_N = 3;

  typedef enum logic [2:0] {
    FORM_ALWAYS, FORM_NEVER, FORM_FLAG, FORM_SIGNED, FORM_LOOPB, FORM_LOOPX
  } br_form_e;

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_DONE} br_state_e;

  typedef struct packed {
    br_form_e   form;
    logic [3:0] cond;     // odd codes are the "set" sense of a flag test
    logic       is_long;
    logic       is_call;
    logic       bad;
  } br_dec_t;

  function automatic br_dec_t br_decode(input logic [7:0] op);
    br_dec_t d;
    d.form    = FORM_NEVER;
    d.cond    = op[3:0];
    d.is_long = 1'b0;
    d.is_call = 1'b0;
    d.bad     = 1'b0;
    if (op[7:4] == 4'h2 || op[7:4] == 4'h3) begin
      d.is_long = op[4];
      case (op[3:0])
        4'h0:                         d.form = FORM_ALWAYS;
        4'h1:                         d.form = FORM_NEVER;
        4'hC, 4'hD, 4'hE, 4'hF:       d.form = FORM_SIGNED;
        default:                      d.form = FORM_FLAG;
      endcase
    end else begin
      case (op)
        OP_BSR:      begin d.form = FORM_ALWAYS; d.is_call = 1'b1; end
        OP_LBSR:     begin d.form = FORM_ALWAYS; d.is_call = 1'b1; d.is_long = 1'b1; end
        OP_DECB_JNZ: d.form = FORM_LOOPB;
        OP_DECX_JNZ: d.form = FORM_LOOPX;
        default:     d.bad = 1'b1;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/jtkcpu_brunit_brcond.sv
// Combinational branch condition: maps branch form, condition code and
// loop-counter-zero to the taken decision.
module jtkcpu_brcond
  import jtkcpu_brunit_pkg::*;
(
  input  br_form_e   form,
  input  logic [3:0] cond,
  input  logic [7:0] cc,
  input  logic       cnt_zero,
  output logic       taken
);

  logic c, v, z, n;
  logic base;

  assign c = cc[CC_C];
  assign v = cc[CC_V];
  assign z = cc[CC_Z];
  assign n = cc[CC_N];

  // base is the odd-coded sense (LS, CS, EQ, VS, MI, LT, LE); even codes invert it
  always_comb begin
    base = 1'b0;
    case (cond[3:1])
      3'b001:  base = z | c;
      3'b010:  base = c;
      3'b011:  base = z;
      3'b100:  base = v;
      3'b101:  base = n;
      3'b110:  base = n ^ v;
      3'b111:  base = (n ^ v) | z;
      default: base = 1'b0;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (form)
      FORM_ALWAYS:             taken = 1'b1;
      FORM_NEVER:              taken = 1'b0;
      FORM_FLAG, FORM_SIGNED:  taken = cond[0] ? base : ~base;
      FORM_LOOPB, FORM_LOOPX:  taken = ~cnt_zero;
      default:                 taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/jtkcpu_brunit.sv
// Sequential branch-resolution unit: IDLE latches a request, EVAL resolves
// it, DONE presents the registered result until the consumer accepts it.
module jtkcpu_brunit
  import jtkcpu_brunit_pkg::*;
#(
  parameter int AW = 16,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          req,
  output logic          req_rdy,
  input  logic [7:0]    op,
  input  logic [7:0]    cc,
  input  logic [AW-1:0] pc,
  input  logic [15:0]   disp,
  input  logic [CW-1:0] cnt_in,
  output logic          res_vld,
  input  logic          res_rdy,
  output logic          taken,
  output logic [AW-1:0] target,
  output logic          is_call,
  output logic          cnt_we,
  output logic [CW-1:0] cnt_out,
  output logic          bad_op
);

  br_state_e state_q, state_d;

  logic [7:0]    op_q, op_d;
  logic [7:0]    cc_q, cc_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [15:0]   disp_q, disp_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          taken_q, taken_d;
  logic [AW-1:0] target_q, target_d;
  logic          is_call_q, is_call_d;
  logic          cnt_we_q, cnt_we_d;
  logic [CW-1:0] cnt_out_q, cnt_out_d;
  logic          bad_op_q, bad_op_d;

  br_dec_t       dec;
  logic [AW-1:0] disp_ext;
  logic [CW-1:0] cnt_dec;
  logic          cnt_zero;
  logic          cond_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req)     state_d = S_EVAL;
      S_EVAL:               state_d = S_DONE;
      S_DONE:  if (res_rdy) state_d = S_IDLE;
      default:              state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  always_comb begin
    req_rdy = (state_q == S_IDLE);
    res_vld = (state_q == S_DONE);
  end

  always_comb begin
    op_d   = op_q;
    cc_d   = cc_q;
    pc_d   = pc_q;
    disp_d = disp_q;
    cnt_d  = cnt_q;
    if (state_q == S_IDLE && req && !flush) begin
      op_d   = op;
      cc_d   = cc;
      pc_d   = pc;
      disp_d = disp;
      cnt_d  = cnt_in;
    end
  end

  // EVAL datapath: decode, displacement sign-extension, adder, decrementer
  always_comb begin
    dec      = br_decode(op_q);
    disp_ext = dec.is_long ? {{(AW-16){disp_q[15]}}, disp_q}
                           : {{(AW-8){disp_q[7]}}, disp_q[7:0]};
    cnt_dec  = cnt_q;
    cnt_zero = 1'b0;
    if (dec.form == FORM_LOOPB) begin
      cnt_dec  = {cnt_q[CW-1:8], cnt_q[7:0] - 8'd1};
      cnt_zero = (cnt_dec[7:0] == 8'd0);
    end else if (dec.form == FORM_LOOPX) begin
      cnt_dec  = cnt_q - CW'(1);
      cnt_zero = (cnt_dec == '0);
    end
  end

  jtkcpu_brcond u_brcond (
    .form     (dec.form),
    .cond     (dec.cond),
    .cc       (cc_q),
    .cnt_zero (cnt_zero),
    .taken    (cond_taken)
  );

  always_comb begin
    taken_d   = taken_q;
    target_d  = target_q;
    is_call_d = is_call_q;
    cnt_we_d  = cnt_we_q;
    cnt_out_d = cnt_out_q;
    bad_op_d  = bad_op_q;
    if (state_q == S_EVAL && !flush) begin
      taken_d   = cond_taken & ~dec.bad;
      target_d  = pc_q + disp_ext;
      is_call_d = dec.is_call & ~dec.bad;
      cnt_we_d  = ~dec.bad & (dec.form == FORM_LOOPB || dec.form == FORM_LOOPX);
      cnt_out_d = cnt_dec;
      bad_op_d  = dec.bad;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      cc_q      <= '0;
      pc_q      <= '0;
      disp_q    <= '0;
      cnt_q     <= '0;
      taken_q   <= 1'b0;
      target_q  <= '0;
      is_call_q <= 1'b0;
      cnt_we_q  <= 1'b0;
      cnt_out_q <= '0;
      bad_op_q  <= 1'b0;
    end else begin
      op_q      <= op_d;
      cc_q      <= cc_d;
      pc_q      <= pc_d;
      disp_q    <= disp_d;
      cnt_q     <= cnt_d;
      taken_q   <= taken_d;
      target_q  <= target_d;
      is_call_q <= is_call_d;
      cnt_we_q  <= cnt_we_d;
      cnt_out_q <= cnt_out_d;
      bad_op_q  <= bad_op_d;
    end
  end

  assign taken   = taken_q;
  assign target  = target_q;
  assign is_call = is_call_q;
  assign cnt_we  = cnt_we_q;
  assign cnt_out = cnt_out_q;
  assign bad_op  = bad_op_q;

endmodule

// File: tb/tb_jtkcpu_brunit.sv
// Scoreboard bench for jtkcpu_brunit: directed cases from the test plan
// followed by randomized requests against a behavioural branch model.
module tb_jtkcpu_brunit;

  typedef struct packed {
    logic        taken;
    logic [15:0] target;
    logic        is_call;
    logic        cnt_we;
    logic [15:0] cnt_out;
    logic        bad_op;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        req = 1'b0;
  logic        req_rdy;
  logic [7:0]  op = '0;
  logic [7:0]  cc = '0;
  logic [15:0] pc = '0;
  logic [15:0] disp = '0;
  logic [15:0] cnt_in = '0;
  logic        res_vld;
  bit          res_rdy;
  logic        taken;
  logic [15:0] target;
  logic        is_call;
  logic        cnt_we;
  logic [15:0] cnt_out;
  logic        bad_op;

  int checks = 0;
  int failures = 0;
  int rdy_mode = 0;  // 0: res_rdy high, 1: res_rdy low, 2: random
  exp_t q[$];

  jtkcpu_brunit #(.AW(16), .CW(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .req(req), .req_rdy(req_rdy),
    .op(op), .cc(cc), .pc(pc), .disp(disp), .cnt_in(cnt_in),
    .res_vld(res_vld), .res_rdy(res_rdy), .taken(taken), .target(target),
    .is_call(is_call), .cnt_we(cnt_we), .cnt_out(cnt_out), .bad_op(bad_op)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       res_rdy = 1'b1;
      1:       res_rdy = 1'b0;
      default: res_rdy = ($urandom_range(0, 1) == 1);
    endcase
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t outs();
    return '{taken, target, is_call, cnt_we, cnt_out, bad_op};
  endfunction

  // Behavioural reference: named condition per opcode, integer arithmetic
  function automatic exp_t model(input logic [7:0] o, input logic [7:0] f,
                                 input logic [15:0] p, input logic [15:0] d,
                                 input logic [15:0] n_in);
    exp_t e;
    bit c = f[0], v = f[1], z = f[2], n = f[3];
    bit known = 1, tk = 0, call = 0, lng = 0, lb = 0, lx = 0;
    int off, lo;
    case (o)
      8'h20, 8'h30: tk = 1;
      8'h21, 8'h31: tk = 0;
      8'h22, 8'h32: tk = !(z || c);
      8'h23, 8'h33: tk = z || c;
      8'h24, 8'h34: tk = !c;
      8'h25, 8'h35: tk = c;
      8'h26, 8'h36: tk = !z;
      8'h27, 8'h37: tk = z;
      8'h28, 8'h38: tk = !v;
      8'h29, 8'h39: tk = v;
      8'h2A, 8'h3A: tk = !n;
      8'h2B, 8'h3B: tk = n;
      8'h2C, 8'h3C: tk = (n == v);
      8'h2D, 8'h3D: tk = (n != v);
      8'h2E, 8'h3E: tk = (n == v) && !z;
      8'h2F, 8'h3F: tk = !((n == v) && !z);
      8'h8D: begin tk = 1; call = 1; end
      8'h17: begin tk = 1; call = 1; lng = 1; end
      8'h8A: lb = 1;
      8'h8B: lx = 1;
      default: known = 0;
    endcase
    if (o >= 8'h30 && o <= 8'h3F) lng = 1;
    off = lng ? int'($signed(d)) : int'($signed(d[7:0]));
    e.target  = 16'((int'(p) + off + 65536) % 65536);
    e.is_call = call;
    e.cnt_we  = lb || lx;
    e.bad_op  = !known;
    e.cnt_out = n_in;
    if (lb) begin
      lo = (int'(n_in[7:0]) + 255) % 256;
      e.cnt_out = 16'(int'(n_in[15:8]) * 256 + lo);
      tk = (lo != 0);
    end
    if (lx) begin
      e.cnt_out = 16'((int'(n_in) + 65535) % 65536);
      tk = (e.cnt_out != 0);
    end
    e.taken = known && tk;
    return e;
  endfunction

  // Issue one request; optionally push its expectation and check latency.
  task automatic send(input logic [7:0] o, input logic [7:0] f, input logic [15:0] p,
                      input logic [15:0] d, input logic [15:0] n, input bit push, input bit lat);
    int w = 0;
    @(negedge clk);
    while (!req_rdy && w < 50) begin @(negedge clk); w++; end
    if (!req_rdy) begin
      chk("req_rdy_timeout", 64'(req_rdy), 64'd1);
      return;
    end
    op = o; cc = f; pc = p; disp = d; cnt_in = n; req = 1'b1;
    @(posedge clk);
    if (push) q.push_back(model(o, f, p, d, n));
    #1 req = 1'b0;
    if (lat) begin
      @(negedge clk);
      chk("lat_eval_vld", 64'(res_vld), 64'd0);
      @(negedge clk);
      chk("lat_done_vld", 64'(res_vld), 64'd1);
    end
  endtask

  task automatic drain();
    int w = 0;
    while (q.size() != 0 && w < 200) begin @(negedge clk); w++; end
    chk("drain_queue", 64'(q.size()), 64'd0);
  endtask

  // Monitor: compares every accepted result against the scoreboard head
  always @(negedge clk) begin
    if (rst_n && res_vld && res_rdy) begin
      chk("busy_req_rdy", 64'(req_rdy), 64'd0);
      if (q.size() == 0) begin
        chk("unexpected_result", 64'(res_vld), 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("result", 64'(outs()), 64'(e));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] valid_ops [0:19];
    exp_t e;
    for (int i = 0; i < 16; i++) valid_ops[i] = 8'(8'h20 + i);
    valid_ops[16] = 8'h8D; valid_ops[17] = 8'h17;
    valid_ops[18] = 8'h8A; valid_ops[19] = 8'h8B;

    repeat (3) @(negedge clk);
    chk("reset_outs", 64'(outs()), 64'd0);
    chk("reset_vld", 64'(res_vld), 64'd0);
    chk("reset_rdy", 64'(req_rdy), 64'd1);
    rst_n = 1'b1;

    // BEQ with a 5-cycle consumer stall
    rdy_mode = 1;
    send(8'h27, 8'h04, 16'h1000, 16'h00F0, 16'h0000, 1, 1);
    e = model(8'h27, 8'h04, 16'h1000, 16'h00F0, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      chk("stall_hold_outs", 64'(outs()), 64'(e));
      chk("stall_hold_vld", 64'(res_vld), 64'd1);
      @(negedge clk);
    end
    rdy_mode = 0;
    drain();

    send(8'h3E, 8'h08, 16'h2000, 16'h0100, 16'h0000, 1, 1);
    send(8'h3E, 8'h0A, 16'hFFF0, 16'h0020, 16'h0000, 1, 1);
    send(8'h17, 8'h00, 16'h9000, 16'h8000, 16'h0000, 1, 1);
    send(8'h8A, 8'h00, 16'h0100, 16'h00FE, 16'h1201, 1, 1);
    send(8'h8A, 8'h00, 16'h0100, 16'h00FE, 16'h3400, 1, 1);
    send(8'h8B, 8'h00, 16'h0100, 16'h00FE, 16'h0000, 1, 1);
    send(8'h8B, 8'h00, 16'h0100, 16'h00FE, 16'h0001, 1, 1);
    drain();

    // Flush in EVAL drops the BRA; next BRN resolves normally
    send(8'h20, 8'h00, 16'h4000, 16'h0010, 16'h0000, 0, 0);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_vld", 64'(res_vld), 64'd0);
    chk("flush_rdy", 64'(req_rdy), 64'd1);
    repeat (2) @(negedge clk);
    chk("flush_no_result", 64'(res_vld), 64'd0);
    send(8'h21, 8'hFF, 16'h4000, 16'h0010, 16'h0000, 1, 1);
    send(8'hFF, 8'h0F, 16'h5000, 16'h0004, 16'h0055, 1, 1);
    drain();

    // Flush together with req in IDLE: not accepted
    @(negedge clk);
    flush = 1'b1; req = 1'b1; op = 8'h20;
    @(negedge clk);
    flush = 1'b0; req = 1'b0;
    chk("flush_req_idle", 64'(req_rdy), 64'd1);

    // Asynchronous reset while DONE
    rdy_mode = 1;
    send(8'h27, 8'h04, 16'h1000, 16'h00F0, 16'h0000, 0, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_done_outs", 64'(outs()), 64'd0);
    chk("rst_done_vld", 64'(res_vld), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rdy_mode = 0;
    @(negedge clk);
    chk("rst_release_rdy", 64'(req_rdy), 64'd1);

    // Randomized requests with random consumer back-pressure
    rdy_mode = 2;
    for (int i = 0; i < 60; i++) begin
      logic [7:0]  o;
      logic [15:0] n;
      o = ($urandom_range(0, 7) == 0) ? 8'($urandom) : valid_ops[$urandom_range(0, 19)];
      n = 16'($urandom);
      if ($urandom_range(0, 3) == 0) n[7:0] = 8'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) n = 16'($urandom_range(0, 1));
      send(o, 8'($urandom), 16'($urandom), 16'($urandom), n, 1, 1);
    end
    rdy_mode = 0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
